// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin share of one 16x9 multiplier.
// Registered operand stage feeds the multiplier; product captured with owner ID.
module mult_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_a,
    input  logic [9*N_REQ-1:0]    req_b,
    output logic [15:0]           mult_a,
    output logic [8:0]            mult_b,
    input  logic [24:0]           mult_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ID_W-1:0]       res_id,
    output logic [24:0]           res_data
);

    localparam logic [ID_W:0]   NREQ = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(N_REQ - 1);

    logic            s1_valid_q, s1_valid_d;
    logic [15:0]     a_q, a_d;
    logic [8:0]      b_q, b_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            res_valid_q, res_valid_d;
    logic [24:0]     res_data_q, res_data_d;
    logic [ID_W-1:0] res_id_q, res_id_d;

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gnt_id;
    logic [ID_W:0]    idx;
    logic             found;
    logic [15:0]      a_sel;
    logic [8:0]       b_sel;
    logic             s1_en, s2_en, accept;

    assign s2_en  = !res_valid_q | res_ready;
    assign s1_en  = !s1_valid_q | s2_en;
    assign accept = found & s1_en;

    assign req_ready = grant & {N_REQ{s1_en}};
    assign mult_a    = a_q;
    assign mult_b    = b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;

    // Round-robin search starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[ID_W-1:0]]    = 1'b1;
                gnt_id                  = idx[ID_W-1:0];
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                a_sel = req_a[16*i +: 16];
                b_sel = req_b[9*i +: 9];
            end
        end
    end

    // Next state for the operand and result stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        if (s1_en) begin
            s1_valid_d = accept;
            if (accept) begin
                a_d   = a_sel;
                b_d   = b_sel;
                id_d  = gnt_id;
                ptr_d = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
            end
        end
        if (s2_en) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_data_d = mult_c;
                res_id_d   = id_q;
            end
        end
    end

    // Pipeline and pointer registers, cleared asynchronously.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: directed and randomised checks of the multiplier arbiter.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mult_rr_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [35:0] req_b;
    logic [15:0] mult_a;
    logic [8:0]  mult_b;
    logic [24:0] mult_c;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  res_id;
    logic [24:0] res_data;

    int n_tests = 0;
    int n_fail  = 0;

    mult_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_c    (mult_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data)
    );

    assign mult_c = 25'(mult_a) * 25'(mult_b);

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [8:0] b);
        req_a[16*i +: 16] = a;
        req_b[9*i +: 9]   = b;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic stream_ops();
        for (int i = 0; i < 4; i++)
            set_op(i, 16'(16'h0100 * (i + 1)), 9'h100);
    endtask

    logic [3:0]  pend;
    logic [15:0] ra [4];
    logic [8:0]  rb [4];
    int          wcnt [4];
    int          q_id [$];
    int          q_dat [$];
    int          n_acc;
    int          n_res;

    initial begin
        req_a = '0;
        req_b = '0;

        // single max-value operation
        do_reset();
        #1;
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_mult_a", 32'(mult_a), 0);
        chk("rst_mult_b", 32'(mult_b), 0);
        chk("rst_data", 32'(res_data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        set_op(0, 16'hFFFF, 9'h1FF);
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        chk("t1_mult_a", 32'(mult_a), 32'hFFFF);
        chk("t1_mult_b", 32'(mult_b), 32'h1FF);
        chk("t1_rv_early", 32'(res_valid), 0);
        @(negedge sys_clk);
        #1;
        chk("t1_rv", 32'(res_valid), 1);
        chk("t1_data", 32'(res_data), 32'h1FEFE01);
        chk("t1_id", 32'(res_id), 0);
        @(negedge sys_clk);
        #1;
        chk("t1_rv_drop", 32'(res_valid), 0);

        // all requesters streaming, res_ready high
        do_reset();
        stream_ops();
        req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge sys_clk);
            #1;
            chk("t2_ready", 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk("t2_rv", 32'(res_valid), 1);
                chk("t2_id", 32'(res_id), 32'((c - 2) % 4));
                chk("t2_data", 32'(res_data),
                    32'(32'h10000 * ((c - 2) % 4 + 1)));
            end
        end

        // backpressure: res_ready low for three cycles
        do_reset();
        stream_ops();
        req_valid = 4'hF;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'h1);
        @(negedge sys_clk);
        #1;
        chk("t3_ready1", 32'(req_ready), 32'h2);
        for (int c = 0; c < 3; c++) begin
            @(negedge sys_clk);
            res_ready = 1'b0;
            #1;
            chk("t3_stall_ready", 32'(req_ready), 0);
            chk("t3_stall_rv", 32'(res_valid), 1);
            chk("t3_stall_id", 32'(res_id), 0);
            chk("t3_stall_data", 32'(res_data), 32'h10000);
        end
        @(negedge sys_clk);
        res_ready = 1'b1;
        #1;
        chk("t3_rel_ready", 32'(req_ready), 32'h4);
        chk("t3_rel_id", 32'(res_id), 0);
        for (int k = 1; k < 4; k++) begin
            @(negedge sys_clk);
            #1;
            chk("t3_rv", 32'(res_valid), 1);
            chk("t3_id", 32'(res_id), 32'(k));
            chk("t3_data", 32'(res_data), 32'(32'h10000 * (k + 1)));
            chk("t3_ready", 32'(req_ready), 32'(1 << ((k + 2) % 4)));
        end

        // fairness after pointer moves to 3, zero operand
        do_reset();
        set_op(2, 16'h1234, 9'h000);
        set_op(1, 16'h0010, 9'h003);
        set_op(3, 16'h0020, 9'h005);
        req_valid = 4'b0100;
        #1;
        chk("t4_ready2", 32'(req_ready), 32'h4);
        @(negedge sys_clk);
        req_valid = 4'b1010;
        #1;
        chk("t4_ready3", 32'(req_ready), 32'h8);
        @(negedge sys_clk);
        #1;
        chk("t4_ready1", 32'(req_ready), 32'h2);
        chk("t4_id2", 32'(res_id), 2);
        chk("t4_zero", 32'(res_data), 0);
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        chk("t4_id3", 32'(res_id), 3);
        chk("t4_data3", 32'(res_data), 32'hA0);
        @(negedge sys_clk);
        #1;
        chk("t4_id1", 32'(res_id), 1);
        chk("t4_data1", 32'(res_data), 32'h30);
        @(negedge sys_clk);
        #1;
        chk("t4_rv_end", 32'(res_valid), 0);

        // asynchronous reset with both stages full
        do_reset();
        stream_ops();
        req_valid = 4'hF;
        res_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        #1;
        chk("t5_full_ready", 32'(req_ready), 0);
        chk("t5_full_rv", 32'(res_valid), 1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("t5_rst_rv", 32'(res_valid), 0);
        chk("t5_rst_ma", 32'(mult_a), 0);
        chk("t5_rst_mb", 32'(mult_b), 0);
        chk("t5_rst_data", 32'(res_data), 0);
        chk("t5_rst_ready", 32'(req_ready), 32'h1);
        req_valid = 4'b1001;
        #1;
        chk("t5_tie_rst", 32'(req_ready), 32'h1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("t5_tie", 32'(req_ready), 32'h1);
        chk("t5_no_stale0", 32'(res_valid), 0);
        @(negedge sys_clk);
        req_valid = '0;
        #1;
        chk("t5_no_stale1", 32'(res_valid), 0);
        chk("t5_mult_a", 32'(mult_a), 32'h0100);
        @(negedge sys_clk);
        #1;
        chk("t5_rv", 32'(res_valid), 1);
        chk("t5_id", 32'(res_id), 0);
        chk("t5_data", 32'(res_data), 32'h10000);

        // randomised traffic against a queue of expected results
        do_reset();
        pend  = '0;
        n_acc = 0;
        n_res = 0;
        for (int i = 0; i < 4; i++) wcnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (cyc < 360 && !pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i]   = 16'($urandom);
                    rb[i]   = 9'($urandom);
                    wcnt[i] = 0;
                    set_op(i, ra[i], rb[i]);
                end
            end
            req_valid = pend;
            res_ready = (cyc >= 360) || ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_onehot", 32'($countones(req_ready) <= 1), 1);
            chk("rnd_subset", 32'(req_ready & ~req_valid), 0);
            if (res_valid && res_ready) begin
                n_res++;
                if (q_id.size() == 0) begin
                    chk("rnd_extra", 32'(res_id), 32'hFFFF_FFFF);
                end else begin
                    chk("rnd_id", 32'(res_id), 32'(q_id.pop_front()));
                    chk("rnd_data", 32'(res_data), 32'(q_dat.pop_front()));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) begin
                    q_id.push_back(i);
                    q_dat.push_back(int'(25'(ra[i]) * 25'(rb[i])));
                    pend[i] = 1'b0;
                    n_acc++;
                end else if (pend[i] && req_ready != 0) begin
                    wcnt[i]++;
                    chk("rnd_starve", 32'(wcnt[i] <= 3), 1);
                end
            end
            @(negedge sys_clk);
        end
        #1;
        chk("rnd_drain", 32'(q_id.size()), 0);
        chk("rnd_count", 32'(n_res), 32'(n_acc));
        chk("rnd_idle", 32'(res_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
